// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity generator/checker.
package parity_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  localparam logic PARITY_ODD  = 1'b1;
  localparam logic PARITY_EVEN = 1'b0;

  // In check mode each frame carries one extra received parity bit.
  function automatic int frame_len(input int width, input bit check);
    return check ? width + 1 : width;
  endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// Frame bit counter: counts accepted bits, wraps to 0 on the terminal bit.
module serial_bit_counter #(
  parameter int TERM  = 3,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign last = inc && (cnt_q == CNT_W'(TERM - 1));
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = last ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_parity_unit.sv
// Serial parity generator, MSB first. Define PARITY_CHECK_EN to add a
// trailing received parity bit per frame and the parity_err output.
module serial_parity_unit
  import parity_pkg::*;
#(
  parameter int MSG_WIDTH = 3,
  parameter int ODD       = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           in_valid,
  input  logic                           in_bit,
  output logic                           parity_out,
  output logic                           parity_valid,
  output logic [MSG_WIDTH-1:0]           msg_out,
  output logic                           busy,
`ifdef PARITY_CHECK_EN
  output logic                           parity_err,
`endif
  output logic [$clog2(MSG_WIDTH+2)-1:0] bit_cnt
);

`ifdef PARITY_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif
  localparam int   FRAME_LEN = frame_len(MSG_WIDTH, CHECK);
  localparam int   CNT_W     = $clog2(MSG_WIDTH + 2);
  localparam logic ACC_INIT  = (ODD != 0) ? PARITY_ODD : PARITY_EVEN;

  state_e                 state_q, state_d;
  logic                   acc_q, acc_d, acc_upd;
  logic [MSG_WIDTH-1:0]   shift_q, shift_d, shift_upd;
  logic [MSG_WIDTH:0]     shift_cat;
  logic                   po_q, po_d, pv_q, pv_d;
  logic [MSG_WIDTH-1:0]   msg_q, msg_d;
  logic                   accept, last, is_data;
  logic [CNT_W-1:0]       cnt;
`ifdef PARITY_CHECK_EN
  logic                   err_q, err_d;
`endif

  assign accept = in_valid & ~clear;

  serial_bit_counter #(
    .TERM  (FRAME_LEN),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc   (accept),
    .clr   (clear),
    .cnt   (cnt),
    .last  (last)
  );

  always_comb begin
    state_d = state_q;
    if (clear)       state_d = IDLE;
    else if (accept) state_d = last ? IDLE : ACCUM;
  end

  // Only the first MSG_WIDTH bits of a frame are data; a trailing bit is the received parity.
  assign is_data   = (cnt < CNT_W'(MSG_WIDTH));
  assign shift_cat = {shift_q, in_bit};
  assign acc_upd   = is_data ? (acc_q ^ in_bit) : acc_q;
  assign shift_upd = is_data ? shift_cat[MSG_WIDTH-1:0] : shift_q;

  always_comb begin
    acc_d   = acc_q;
    shift_d = shift_q;
    po_d    = po_q;
    msg_d   = msg_q;
    pv_d    = 1'b0;
`ifdef PARITY_CHECK_EN
    err_d   = err_q;
`endif
    if (clear) begin
      acc_d   = ACC_INIT;
      shift_d = '0;
    end else if (in_valid) begin
      if (last) begin
        po_d    = acc_upd;
        msg_d   = shift_upd;
        pv_d    = 1'b1;
        acc_d   = ACC_INIT;
        shift_d = '0;
`ifdef PARITY_CHECK_EN
        err_d   = in_bit ^ acc_upd;
`endif
      end else begin
        acc_d   = acc_upd;
        shift_d = shift_upd;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= ACC_INIT;
      shift_q <= '0;
      po_q    <= 1'b0;
      pv_q    <= 1'b0;
      msg_q   <= '0;
`ifdef PARITY_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      shift_q <= shift_d;
      po_q    <= po_d;
      pv_q    <= pv_d;
      msg_q   <= msg_d;
`ifdef PARITY_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign parity_out   = po_q;
  assign parity_valid = pv_q;
  assign msg_out      = msg_q;
  assign bit_cnt      = cnt;
  assign busy         = (cnt != '0);
`ifdef PARITY_CHECK_EN
  assign parity_err   = err_q;
`endif

endmodule

// File: tb/tb_serial_parity_unit.sv
// Bench for serial_parity_unit: a 3-bit/odd and an 8-bit/even instance share stimulus.
module tb_serial_parity_unit;

`ifdef PARITY_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;

  logic       po0, pv0, busy0;
  logic [2:0] msg0;
  logic [2:0] cnt0;
  logic       po1, pv1, busy1;
  logic [7:0] msg1;
  logic [3:0] cnt1;
`ifdef PARITY_CHECK_EN
  logic       err0, err1;
`endif

  serial_parity_unit #(.MSG_WIDTH(3), .ODD(1)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
    .parity_out(po0), .parity_valid(pv0), .msg_out(msg0), .busy(busy0),
`ifdef PARITY_CHECK_EN
    .parity_err(err0),
`endif
    .bit_cnt(cnt0)
  );

  serial_parity_unit #(.MSG_WIDTH(8), .ODD(0)) dut8 (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
    .parity_out(po1), .parity_valid(pv1), .msg_out(msg1), .busy(busy1),
`ifdef PARITY_CHECK_EN
    .parity_err(err1),
`endif
    .bit_cnt(cnt1)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: bits of the current frame are collected; parity and the
  // message word are computed arithmetically once the frame is complete.
  int W[2]  = '{3, 8};
  int OD[2] = '{1, 0};
  int nb[2];
  int fb[2][16];
  int exp_pv[2], exp_po[2], exp_msg[2], exp_err[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      nb[i] = 0; exp_pv[i] = 0; exp_po[i] = 0; exp_msg[i] = 0; exp_err[i] = 0;
    end
  endtask

  task automatic model_edge(input logic v, input logic b, input logic c);
    int ones, m, par;
    for (int i = 0; i < 2; i++) begin
      exp_pv[i] = 0;
      if (c) nb[i] = 0;
      else if (v) begin
        fb[i][nb[i]] = int'(b);
        nb[i]++;
        if (nb[i] == W[i] + CHK) begin
          ones = 0; m = 0;
          for (int k = 0; k < W[i]; k++) begin
            m = m * 2 + fb[i][k];
            ones += fb[i][k];
          end
          par = (ones + OD[i]) % 2;
          exp_pv[i] = 1; exp_po[i] = par; exp_msg[i] = m;
          if (CHK == 1) exp_err[i] = (fb[i][W[i]] != par) ? 1 : 0;
          nb[i] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("pv0", pv0, exp_pv[0]);   chk("po0", po0, exp_po[0]);
    chk("msg0", msg0, exp_msg[0]); chk("busy0", busy0, (nb[0] != 0));
    chk("cnt0", cnt0, nb[0]);
    chk("pv1", pv1, exp_pv[1]);   chk("po1", po1, exp_po[1]);
    chk("msg1", msg1, exp_msg[1]); chk("busy1", busy1, (nb[1] != 0));
    chk("cnt1", cnt1, nb[1]);
`ifdef PARITY_CHECK_EN
    chk("err0", err0, exp_err[0]); chk("err1", err1, exp_err[1]);
`endif
  endtask

  task automatic step(input logic v, input logic b, input logic c);
    in_valid = v; in_bit = b; clear = c;
    @(posedge clk);
    model_edge(v, b, c);
    #1;
    check_all();
  endtask

  initial begin
    logic [2:0] vv;
    logic [7:0] a7;
    logic       rv, rb, rc;
    model_reset();
    #12;
    check_all();
    reset = 1'b1;

`ifndef PARITY_CHECK_EN
    // Basic frame 1,0,1 on the 3-bit odd instance
    step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
    chk("tp1_pv", pv0, 1); chk("tp1_par", po0, 1); chk("tp1_msg", msg0, 3'b101);
    step(0, 0, 0);
    chk("tp1_pulse_end", pv0, 0);

    // Back-to-back sweep of all 3-bit values
    step(0, 0, 1);
    for (int v = 0; v < 8; v++) begin
      vv = v[2:0];
      for (int k = 2; k >= 0; k--) step(1, vv[k], 0);
      chk("sweep_pv", pv0, 1); chk("sweep_par", po0, ~^vv); chk("sweep_msg", msg0, vv);
    end

    // 8'hA7 with a gap after every bit on the 8-bit even instance
    step(0, 0, 1);
    a7 = 8'hA7;
    for (int k = 7; k >= 0; k--) begin
      step(1, a7[k], 0);
      chk("a7_cnt", cnt1, (8 - k) % 8);
      if (k == 0) begin
        chk("a7_pv", pv1, 1); chk("a7_par", po1, 1); chk("a7_msg", msg1, 8'hA7);
      end
      step(0, $urandom_range(0, 1), 0);
      chk("a7_gap_cnt", cnt1, (8 - k) % 8);
    end

    // Abort after two bits, clear beating in_valid, then 1,1,1
    step(0, 0, 1);
    step(1, 1, 0); step(1, 1, 0);
    step(0, 0, 1);
    chk("clr_busy", busy0, 0); chk("clr_nopulse", pv0, 0);
    step(1, 0, 1);
    chk("clr_drop_cnt", cnt0, 0);
    step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
    chk("clr_pv", pv0, 1); chk("clr_par", po0, 0); chk("clr_msg", msg0, 3'b111);

    // Asynchronous reset one bit into a frame
    step(1, 1, 0);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("rst_msg0", msg0, 0); chk("rst_busy0", busy0, 0); chk("rst_cnt0", cnt0, 0);
    check_all();
    #2 reset = 1'b1;
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
    chk("rst_pv", pv0, 1); chk("rst_par", po0, 1); chk("rst_msg", msg0, 0);
`else
    // Received parity wrong, then right, on the 3-bit odd instance
    step(0, 0, 1);
    step(1, 1, 0); step(1, 0, 0); step(1, 1, 0); step(1, 0, 0);
    chk("chk_pv", pv0, 1); chk("chk_err1", err0, 1); chk("chk_par", po0, 1);
    chk("chk_msg", msg0, 3'b101);
    step(1, 1, 0); step(1, 0, 0); step(1, 1, 0); step(1, 1, 0);
    chk("chk_err0", err0, 0); chk("chk_par2", po0, 1);
    step(0, 0, 0);
    chk("chk_err_hold", err0, 0);
`endif

    // Random traffic with gaps and occasional aborts
    for (int n = 0; n < 400; n++) begin
      rv = ($urandom_range(0, 3) != 0);
      rb = $urandom_range(0, 1);
      rc = ($urandom_range(0, 31) == 0);
      step(rv, rb, rc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
